// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer, a mid-bit
// sampling state machine and one-cycle valid / frame_err pulses.
module uart_rx #(
  parameter int unsigned BIT_CLKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CLKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic          rxd_m;
  logic          rxd_s;
  logic          prev;
  logic [1:0]    warm;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  // Synchronizer, edge history and receive state machine with registered outputs.
  // prev only starts tracking rxd_s once the synchronizer holds real line
  // samples (warm), so the forced-high reset value of rxd_s can never pair
  // with a line that is already low to fake a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rxd_m     <= 1'b1;
      rxd_s     <= 1'b1;
      prev      <= 1'b0;
      warm      <= 2'b00;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rxd_m     <= rxd;
      rxd_s     <= rxd_m;
      warm      <= {warm[0], 1'b1};
      prev      <= rxd_s & warm[1];
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (prev && !rxd_s) begin
            cnt   <= HALF_LOAD;
            idx   <= '0;
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!rxd_s) begin
              cnt   <= FULL_LOAD;
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg[idx] <= rxd_s;
            idx        <= idx + 3'd1;
            cnt        <= FULL_LOAD;
            if (idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STOP: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (rxd_s) begin
              data  <= shreg;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx (BIT_CLKS = 16).
module tb_uart_rx;

  localparam int BC      = 16;
  localparam int LATENCY = 2 + BC / 2 + 9 * BC;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  typedef struct {
    bit         err;
    logic [7:0] d;
    int         at;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] last_good;

  uart_rx #(.BIT_CLKS(BC)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop expectations when the DUT pulses, flag overdue or stray pulses.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && cyc > q[0].at) begin
      tests++;
      fails++;
      $display("FAIL missing_pulse expected at cycle %0d (err=%0d data=%h), not observed by %0d",
               q[0].at, q[0].err, q[0].d, cyc);
      e = q.pop_front();
    end
    if (valid && frame_err) begin
      tests++;
      fails++;
      $display("FAIL both_pulses valid and frame_err high together at cycle %0d", cyc);
    end
    if (valid || frame_err) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse valid=%0d frame_err=%0d data=%h at cycle %0d",
                 valid, frame_err, data, cyc);
      end else begin
        e = q.pop_front();
        if (frame_err !== e.err || valid !== !e.err || data !== e.d || cyc != e.at) begin
          fails++;
          $display("FAIL pulse got valid=%0d err=%0d data=%h cycle=%0d, want valid=%0d err=%0d data=%h cycle=%0d",
                   valid, frame_err, data, cyc, !e.err, e.err, e.d, e.at);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one full frame starting now; queue the response it must produce.
  task automatic send(input logic [7:0] b, input logic stopb);
    exp_t e;
    e.err = !stopb;
    e.d   = stopb ? b : last_good;
    e.at  = cyc + 1 + LATENCY;
    q.push_back(e);
    if (stopb) last_good = b;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_start", 32'(busy), 32'd1);
    repeat (BC - 4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BC) @(negedge clk);
      if (i == 4) check("busy_data", 32'(busy), 32'd1);
    end
    rxd = stopb;
    repeat (BC) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
  endtask

  task automatic check_reset_state();
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] abort_b;
    logic       stopb;
    logic       last_stop;
    int         gap;
    rxd = 1'b1;
    last_good = 8'h00;
    @(negedge clk);
    do_reset(3);
    check_reset_state();
    idle(10);

    // Single good frame, then a bad-stop frame.
    send(8'h61, 1'b1);
    idle(20);
    check("data_after_61", 32'(data), 32'h61);
    send(8'h62, 1'b0);
    idle(20);
    check("data_kept_on_ferr", 32'(data), 32'h61);

    // Short glitch must be rejected.
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_glitch", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    check("idle_after_glitch", 32'(busy), 32'd0);
    check("data_after_glitch", 32'(data), 32'h61);
    idle(10);

    // Back-to-back frames.
    send(8'h61, 1'b1);
    send(8'h62, 1'b1);
    idle(20);
    check("data_b2b", 32'(data), 32'h62);

    // Reset during data bit 3 aborts the frame.
    abort_b = 8'h5A;
    rxd = 1'b0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd = abort_b[i];
      repeat (BC) @(negedge clk);
    end
    rxd = abort_b[3];
    repeat (BC / 2) @(negedge clk);
    do_reset(1);
    check_reset_state();
    idle(BC);
    send(8'hA5, 1'b1);
    idle(20);
    check("data_after_abort", 32'(data), 32'hA5);

    // Reset with the line held low: no false start.
    rxd = 1'b0;
    do_reset(2);
    check_reset_state();
    repeat (20) @(negedge clk);
    check("busy_low_line", 32'(busy), 32'd0);
    idle(BC);
    check("busy_after_low", 32'(busy), 32'd0);
    send(8'h3C, 1'b1);
    idle(20);
    check("data_3c", 32'(data), 32'h3C);

    // Randomized frames, gaps and glitches.
    last_stop = 1'b1;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        idle(3);
        rxd = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        idle(BC + 4);
        last_stop = 1'b1;
      end else begin
        gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
        if (!last_stop && gap < 3) gap = 3;
        if (gap > 0) idle(gap);
        stopb = ($urandom_range(0, 3) != 0);
        send(8'($urandom), stopb);
        last_stop = stopb;
      end
    end
    idle(LATENCY + 40);
    check("queue_drained", 32'(q.size()), 32'd0);
    check("final_data", 32'(data), 32'(last_good));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
